// File: rtl/pc_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pc_gen_pkg                                         |
// | Description : Shared definitions for the fetch PC generator:     |
// |               reset PC default, FSM state encodings and the      |
// |               active level of the request/redirect enables.      |
// | Ports       : none (package)                                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package pc_gen_pkg;

  // Default PC after reset
  localparam logic [31:0] c_RST_PC_DEFAULT = 32'h8000_0000;

  // Active level of fetch_en_i and of all redirect enables
  localparam logic c_EN_ACTIVE = 1'b1;

  // Fetch FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } pc_state_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pc_sel                                             |
// | Description : Combinational redirect selector. Picks one target  |
// |               from trap, mret and branch with fixed priority     |
// |               trap > mret > branch.                              |
// | Ports       : trap_en_i/trap_pc_i     trap redirect               |
// |               mret_en_i/mepc_i        return-from-trap redirect   |
// |               branch_en_i/dnpc_i      branch/jump redirect        |
// |               sel_vld_o/sel_pc_o      selected redirect + target  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module pc_sel
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              mret_en_i,
  input  logic [ADDR_W-1:0] mepc_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic              sel_vld_o,
  output logic [ADDR_W-1:0] sel_pc_o
);

  always_comb begin
    sel_vld_o = 1'b0;
    sel_pc_o  = '0;
    if (trap_en_i == c_EN_ACTIVE) begin
      sel_vld_o = 1'b1;
      sel_pc_o  = trap_pc_i;
    end else if (mret_en_i == c_EN_ACTIVE) begin
      sel_vld_o = 1'b1;
      sel_pc_o  = mepc_i;
    end else if (branch_en_i == c_EN_ACTIVE) begin
      sel_vld_o = 1'b1;
      sel_pc_o  = dnpc_i;
    end
  end

endmodule : pc_sel
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pc_gen                                             |
// | Description : Instruction fetch PC generator. Issues one fetch   |
// |               at a time on an address/data handshake, steps the  |
// |               PC sequentially and applies trap/mret/branch       |
// |               redirects. Redirects seen while a fetch is in      |
// |               flight are held pending and make the returning     |
// |               instruction stale (dropped).                       |
// | Ports       : clk, rst (async, active-low)                       |
// |               fetch_en_i                 permit next fetch        |
// |               trap/mret/branch en + pc   redirect requests        |
// |               arvalid_o/arready_i/araddr_o  fetch address chan.  |
// |               rvalid_i/rready_o          fetch data channel       |
// |               inst_valid_o/inst_drop_o   returned inst. verdict   |
// |               pc_o                       current fetch address    |
// |               fetch_cnt_o                delivered inst. count    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(c_RST_PC_DEFAULT),
  parameter int                STEP   = 4,
  parameter int                CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en_i,
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              mret_en_i,
  input  logic [ADDR_W-1:0] mepc_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              inst_valid_o,
  output logic              inst_drop_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_pend_vld;
  logic              w_pend_vld_nxt;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] w_pend_pc_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_sel_vld;
  logic [ADDR_W-1:0] w_sel_pc;
  logic              w_arvalid;
  logic              w_rready;
  logic              w_inst_valid;
  logic              w_inst_drop;

  pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_sel (
    .trap_en_i   (trap_en_i),
    .trap_pc_i   (trap_pc_i),
    .mret_en_i   (mret_en_i),
    .mepc_i      (mepc_i),
    .branch_en_i (branch_en_i),
    .dnpc_i      (dnpc_i),
    .sel_vld_o   (w_sel_vld),
    .sel_pc_o    (w_sel_pc)
  );

  // State, PC, pending redirect and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RST_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state and output decode. Handshake outputs are decoded from the
  // state register, so an asynchronous reset clears them immediately.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_pc_nxt  = r_pend_pc;
    w_cnt_nxt      = r_cnt;
    w_arvalid      = 1'b0;
    w_rready       = 1'b0;
    w_inst_valid   = 1'b0;
    w_inst_drop    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Nothing in flight: a redirect simply retargets the next fetch
        if (w_sel_vld) begin
          w_pc_nxt = w_sel_pc;
        end
        if (fetch_en_i == c_EN_ACTIVE) begin
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        w_arvalid = 1'b1;
        // araddr_o must stay stable, so park the redirect; a newer one wins
        if (w_sel_vld) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_pc_nxt  = w_sel_pc;
        end
        if (arready_i) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        w_rready = 1'b1;
        if (rvalid_i) begin
          if (w_sel_vld || r_pend_vld) begin
            w_inst_drop = 1'b1;
          end else begin
            w_inst_valid = 1'b1;
            w_cnt_nxt    = r_cnt + CNT_W'(1);
          end
          // Same-cycle redirect is newer than the pending one
          if (w_sel_vld) begin
            w_pc_nxt = w_sel_pc;
          end else if (r_pend_vld) begin
            w_pc_nxt = r_pend_pc;
          end else begin
            w_pc_nxt = r_pc + ADDR_W'(STEP);
          end
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = (fetch_en_i == c_EN_ACTIVE) ? ST_ADDR : ST_IDLE;
        end else if (w_sel_vld) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_pc_nxt  = w_sel_pc;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign arvalid_o    = w_arvalid;
  assign rready_o     = w_rready;
  assign inst_valid_o = w_inst_valid;
  assign inst_drop_o  = w_inst_drop;
  assign araddr_o     = r_pc;
  assign pc_o         = r_pc;
  assign fetch_cnt_o  = r_cnt;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_pc_gen                                          |
// | Description : Directed self-checking bench for pc_gen. Expected  |
// |               fetch addresses and valid/drop verdicts are queued |
// |               when stimulus is driven and compared when the DUT  |
// |               presents them.                                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_en_i;
  logic        trap_en_i;
  logic [31:0] trap_pc_i;
  logic        mret_en_i;
  logic [31:0] mepc_i;
  logic        branch_en_i;
  logic [31:0] dnpc_i;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic        rvalid_i;
  logic        rready_o;
  logic        inst_valid_o;
  logic        inst_drop_o;
  logic [31:0] pc_o;
  logic [31:0] fetch_cnt_o;

  int          checks;
  int          errors;
  logic [31:0] exp_addr_q[$];
  logic        exp_kind_q[$];   // 1 = inst_valid_o expected, 0 = inst_drop_o

  pc_gen #(
    .ADDR_W (32),
    .RST_PC (32'h8000_0000),
    .STEP   (4),
    .CNT_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en_i   (fetch_en_i),
    .trap_en_i    (trap_en_i),
    .trap_pc_i    (trap_pc_i),
    .mret_en_i    (mret_en_i),
    .mepc_i       (mepc_i),
    .branch_en_i  (branch_en_i),
    .dnpc_i       (dnpc_i),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .araddr_o     (araddr_o),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .inst_valid_o (inst_valid_o),
    .inst_drop_o  (inst_drop_o),
    .pc_o         (pc_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address phase: optional stall cycles with redirects driven in stall 0 / 1.
  // Redirect bits are {trap, mret, branch}.
  task automatic fetch_addr(input int stall, input logic [2:0] r1, input logic [2:0] r2);
    int          n;
    logic [31:0] exp;
    n = 0;
    while (!arvalid_o && n < 20) begin
      tick();
      n++;
    end
    check("arvalid_wait", {31'd0, arvalid_o}, 32'd1);
    exp = exp_addr_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      arready_i = 1'b0;
      if (i == 0)      {trap_en_i, mret_en_i, branch_en_i} = r1;
      else if (i == 1) {trap_en_i, mret_en_i, branch_en_i} = r2;
      else             {trap_en_i, mret_en_i, branch_en_i} = 3'b000;
      #1;
      check("araddr_stall", araddr_o, exp);
      tick();
    end
    {trap_en_i, mret_en_i, branch_en_i} = 3'b000;
    arready_i = 1'b1;
    #1;
    check("araddr", araddr_o, exp);
    tick();
    arready_i = 1'b0;
  endtask

  // Data phase: return the instruction and compare the valid/drop verdict.
  task automatic fetch_data(input logic next_en);
    logic k;
    check("rready", {31'd0, rready_o}, 32'd1);
    fetch_en_i = next_en;
    rvalid_i   = 1'b1;
    #1;
    k = exp_kind_q.pop_front();
    check("inst_valid", {31'd0, inst_valid_o}, {31'd0, k});
    check("inst_drop", {31'd0, inst_drop_o}, {31'd0, !k});
    tick();
    rvalid_i = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    fetch_en_i  = 1'b0;
    trap_en_i   = 1'b0;
    trap_pc_i   = '0;
    mret_en_i   = 1'b0;
    mepc_i      = '0;
    branch_en_i = 1'b0;
    dnpc_i      = '0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("rst_rready", {31'd0, rready_o}, 32'd0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_drop", {31'd0, inst_drop_o}, 32'd0);
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_cnt", fetch_cnt_o, 32'd0);

    // Reset release with fetch_en and arready high at once
    rst        = 1'b1;
    fetch_en_i = 1'b1;
    arready_i  = 1'b1;
    exp_addr_q.push_back(32'h8000_0000);
    #1;
    check("idle_arvalid", {31'd0, arvalid_o}, 32'd0);
    tick();
    check("first_fetch_arvalid", {31'd0, arvalid_o}, 32'd1);
    fetch_addr(0, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    exp_addr_q.push_back(32'h8000_0004);
    fetch_data(1'b1);
    check("step_pc", pc_o, 32'h8000_0004);
    check("cnt_1", fetch_cnt_o, 32'd1);
    fetch_addr(0, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    fetch_data(1'b0);
    check("idle_arvalid2", {31'd0, arvalid_o}, 32'd0);
    check("idle_rready", {31'd0, rready_o}, 32'd0);
    check("idle_pc", pc_o, 32'h8000_0008);

    // Branch in IDLE
    branch_en_i = 1'b1;
    dnpc_i      = 32'h8000_0100;
    #1;
    check("idle_br_drop", {31'd0, inst_drop_o}, 32'd0);
    tick();
    branch_en_i = 1'b0;
    check("idle_br_pc", pc_o, 32'h8000_0100);
    fetch_en_i = 1'b1;
    exp_addr_q.push_back(32'h8000_0100);
    tick();
    fetch_addr(0, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    exp_addr_q.push_back(32'h8000_0104);
    fetch_data(1'b1);
    check("cnt_3", fetch_cnt_o, 32'd3);

    // Branch while in DATA -> stale return dropped
    fetch_addr(0, 3'b000, 3'b000);
    branch_en_i = 1'b1;
    dnpc_i      = 32'h8000_0200;
    #1;
    check("data_br_valid", {31'd0, inst_valid_o}, 32'd0);
    check("data_br_drop", {31'd0, inst_drop_o}, 32'd0);
    tick();
    branch_en_i = 1'b0;
    check("data_br_pc_hold", araddr_o, 32'h8000_0104);
    exp_kind_q.push_back(1'b0);
    exp_addr_q.push_back(32'h8000_0200);
    fetch_data(1'b1);
    check("drop_cnt", fetch_cnt_o, 32'd3);
    fetch_addr(3, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    fetch_data(1'b1);
    check("br_step_pc", pc_o, 32'h8000_0204);
    check("cnt_4", fetch_cnt_o, 32'd4);

    // trap + mret + branch together in ADDR -> trap wins
    trap_pc_i = 32'h8000_1000;
    mepc_i    = 32'h8000_2000;
    dnpc_i    = 32'h8000_3000;
    exp_addr_q.push_back(32'h8000_0204);
    fetch_addr(2, 3'b111, 3'b000);
    exp_kind_q.push_back(1'b0);
    fetch_data(1'b1);
    check("prio_pc", pc_o, 32'h8000_1000);

    // Later redirect overwrites the pending one (branch then mret)
    exp_addr_q.push_back(32'h8000_1000);
    fetch_addr(2, 3'b001, 3'b010);
    exp_kind_q.push_back(1'b0);
    fetch_data(1'b1);
    check("overwrite_pc", pc_o, 32'h8000_2000);
    check("cnt_still_4", fetch_cnt_o, 32'd4);

    // Redirect arriving in the same cycle as rvalid
    exp_addr_q.push_back(32'h8000_2000);
    fetch_addr(0, 3'b000, 3'b000);
    trap_pc_i = 32'h8000_4000;
    trap_en_i = 1'b1;
    exp_kind_q.push_back(1'b0);
    fetch_data(1'b0);
    trap_en_i = 1'b0;
    check("conc_pc", pc_o, 32'h8000_4000);
    check("conc_idle", {31'd0, arvalid_o}, 32'd0);

    // Sequential wrap at the top of the address space
    branch_en_i = 1'b1;
    dnpc_i      = 32'hFFFF_FFFC;
    tick();
    branch_en_i = 1'b0;
    check("wrap_load", pc_o, 32'hFFFF_FFFC);
    fetch_en_i = 1'b1;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    tick();
    fetch_addr(0, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    fetch_data(1'b1);
    check("wrap_pc", pc_o, 32'h0000_0000);
    check("cnt_5", fetch_cnt_o, 32'd5);

    // Reset mid-DATA with a redirect pending
    exp_addr_q.push_back(32'h0000_0000);
    fetch_addr(0, 3'b000, 3'b000);
    branch_en_i = 1'b1;
    dnpc_i      = 32'h8000_0500;
    tick();
    branch_en_i = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("mid_rst_rready", {31'd0, rready_o}, 32'd0);
    check("mid_rst_pc", pc_o, 32'h8000_0000);
    check("mid_rst_cnt", fetch_cnt_o, 32'd0);
    rvalid_i = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("mid_rst_drop", {31'd0, inst_drop_o}, 32'd0);
    tick();
    rst        = 1'b1;
    fetch_en_i = 1'b0;
    #1;
    check("idle_rvalid_valid", {31'd0, inst_valid_o}, 32'd0);
    check("idle_rvalid_drop", {31'd0, inst_drop_o}, 32'd0);
    tick();
    rvalid_i = 1'b0;
    check("idle_rvalid_pc", pc_o, 32'h8000_0000);
    check("idle_rvalid_cnt", fetch_cnt_o, 32'd0);

    // Pending redirect must be gone: next return is valid, steps from RST_PC
    fetch_en_i = 1'b1;
    exp_addr_q.push_back(32'h8000_0000);
    tick();
    fetch_addr(0, 3'b000, 3'b000);
    exp_kind_q.push_back(1'b1);
    fetch_data(1'b0);
    check("post_rst_pc", pc_o, 32'h8000_0004);
    check("post_rst_cnt", fetch_cnt_o, 32'd1);

    check("addr_q_empty", exp_addr_q.size(), 32'd0);
    check("kind_q_empty", exp_kind_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_gen
`default_nettype wire
